// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder: funct3 size encodings,
// the responder state type and small helpers used at the MEM stage.
package riscv_pkg;

    // funct3[1:0] access size encodings
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // funct3 bit that selects zero-extension on loads
    localparam int F3_UNSIGNED_BIT = 2;

    // Largest supported access latency; sizes the down-counter
    localparam int LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } rsp_state_e;

    // Copy the low byte/half of rs2 into every lane it may be written to;
    // the byte mask then picks the lane(s) actually stored.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size,
                                                   input logic [31:0] data);
        case (size)
            SZ_B:    return {4{data[7:0]}};
            SZ_H:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // Half on an odd address or word not on a 4-byte boundary
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] low_addr);
        return ((size == SZ_H) && low_addr[0]) ||
               ((size == SZ_W) && (low_addr != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised single-port synchronous RAM with per-byte write enables and
// a registered read port. Contents are never reset.
module dmem_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Enabled access: write selected byte lanes and register the old word
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder at the MEM end of EX/MEM. Accepts one load/store at a
// time, holds the pipeline for LATENCY cycles, commits stores / reads the RAM
// on the edge entering DONE and presents extended load data during DONE.
// Optional alignment checking is built when DMEM_MISALIGN_CHECK_EN is defined.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2      // 1..LATENCY_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  mask_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misaligned_o
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY_MAX + 1);

    rsp_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Request fields captured at acceptance
    logic             wr_q;
    logic [2:0]       f3_q;
    logic [AW+1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       mask_q;

    logic             req;
    logic             in_idle;
    logic             accept;
    logic             enter_done;
    logic             is_done;

    // RAM-side selection: in IDLE the access may complete on the very next
    // edge (LATENCY=1), so the live inputs drive the RAM; later the latched copy.
    logic             sel_wr;
    logic [1:0]       sel_size;
    logic [AW+1:0]    sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_mask;
    logic             sel_mis;
    logic             mis_now;

    logic             ram_en;
    logic [3:0]       ram_we;
    logic [31:0]      ram_rdata;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_ext;

    logic             unused_addr_bits;
    assign unused_addr_bits = ^addr_i[31:AW+2];

    assign req        = valid_i & (mem_read_i | mem_write_i);
    assign in_idle    = (state_q == IDLE);
    assign accept     = in_idle & req;
    assign is_done    = (state_q == DONE);
    assign enter_done = (accept && (LATENCY == 1)) ||
                        ((state_q == BUSY) && (cnt_q == CNT_W'(1)));

    assign sel_wr    = in_idle ? mem_write_i : wr_q;
    assign sel_size  = in_idle ? funct3_i[1:0] : f3_q[1:0];
    assign sel_addr  = in_idle ? addr_i[AW+1:0] : addr_q;
    assign sel_wdata = in_idle ? lane_replicate(funct3_i[1:0], wdata_i) : wdata_q;
    assign sel_mask  = in_idle ? mask_i : mask_q;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic mis_q;
    assign sel_mis      = is_misaligned(sel_size, sel_addr[1:0]);
    assign mis_now      = mis_q;
    assign misaligned_o = is_done & mis_q;

    // Misalignment flag captured with the request
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= sel_mis;
        end
    end
`else
    assign sel_mis      = 1'b0;
    assign mis_now      = 1'b0;
    assign misaligned_o = 1'b0;
    logic unused_size;
    assign unused_size  = ^sel_size;
`endif

    // A reset on the commit edge abandons the access, so gate the RAM with rst
    assign ram_en = enter_done & ~rst;
    assign ram_we = (ram_en & sel_wr & ~sel_mis) ? sel_mask : 4'b0000;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk    (clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (sel_addr[AW+1:2]),
        .wdata_i(sel_wdata),
        .rdata_o(ram_rdata)
    );

    // Next-state logic: IDLE accepts, BUSY counts down, DONE always returns
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= mem_write_i;
                f3_q    <= funct3_i;
                addr_q  <= addr_i[AW+1:0];
                wdata_q <= lane_replicate(funct3_i[1:0], wdata_i);
                mask_q  <= mask_i;
            end
        end
    end

    // Lane select and sign/zero extension of the registered RAM word
    always_comb begin
        ld_byte  = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half  = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_ext = ram_rdata;
        case (f3_q[1:0])
            SZ_B: load_ext = f3_q[F3_UNSIGNED_BIT] ? {24'b0, ld_byte}
                                                   : {{24{ld_byte[7]}}, ld_byte};
            SZ_H: load_ext = f3_q[F3_UNSIGNED_BIT] ? {16'b0, ld_half}
                                                   : {{16{ld_half[15]}}, ld_half};
            default: load_ext = ram_rdata;
        endcase
    end

    assign stall_o       = accept | (state_q == BUSY);
    assign rdata_valid_o = is_done & ~wr_q;
    assign rdata_o       = (rdata_valid_o & ~mis_now) ? load_ext : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance at
// LATENCY=2 and one at LATENCY=1, expected values hand-computed.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: LATENCY=2
    logic        a_valid, a_rd, a_wr;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_mask;
    logic        a_stall, a_rdv, a_mis;
    logic [31:0] a_rdata;

    // Instance B: LATENCY=1
    logic        b_valid, b_rd, b_wr;
    logic [2:0]  b_f3;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_mask;
    logic        b_stall, b_rdv, b_mis;
    logic [31:0] b_rdata;

    dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .valid_i(a_valid), .mem_read_i(a_rd),
        .mem_write_i(a_wr), .funct3_i(a_f3), .addr_i(a_addr), .wdata_i(a_wdata),
        .mask_i(a_mask), .stall_o(a_stall), .rdata_o(a_rdata),
        .rdata_valid_o(a_rdv), .misaligned_o(a_mis)
    );

    dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .valid_i(b_valid), .mem_read_i(b_rd),
        .mem_write_i(b_wr), .funct3_i(b_f3), .addr_i(b_addr), .wdata_i(b_wdata),
        .mask_i(b_mask), .stall_o(b_stall), .rdata_o(b_rdata),
        .rdata_valid_o(b_rdv), .misaligned_o(b_mis)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit sel, input logic v, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
        if (!sel) begin
            a_valid = v; a_rd = v & ~wr; a_wr = v & wr;
            a_f3 = f3; a_addr = addr; a_wdata = wdata; a_mask = mask;
        end else begin
            b_valid = v; b_rd = v & ~wr; b_wr = v & wr;
            b_f3 = f3; b_addr = addr; b_wdata = wdata; b_mask = mask;
        end
    endtask

    // Drive one access, count stalled cycles, capture outputs in DONE.
    // Entered and left just after a rising edge with the DUT in IDLE.
    task automatic access(input bit sel, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input bit drop,
                          output int stalls, output logic rdv,
                          output logic [31:0] rd, output logic mis);
        bit done = 0;
        stalls = 0; rdv = 0; rd = '0; mis = 0;
        set_in(sel, 1'b1, wr, f3, addr, wdata, mask);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((sel ? b_stall : a_stall) === 1'b1) begin
                stalls++;
                @(posedge clk); #1;
                if (drop) set_in(sel, 1'b0, 1'b0, 3'b0, '0, '0, 4'b0);
            end else begin
                rdv  = sel ? b_rdv : a_rdv;
                rd   = sel ? b_rdata : a_rdata;
                mis  = sel ? b_mis : a_mis;
                done = 1;
                break;
            end
        end
        if (!done) check("access_timeout", 32'd1, 32'd0);
        set_in(sel, 1'b0, 1'b0, 3'b0, '0, '0, 4'b0);
        @(posedge clk); #1;
    endtask

    int          st;
    logic        v, m;
    logic [31:0] d;

    // Store on instance A, expecting 2 stall cycles and no load data in DONE
    task automatic store_a(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
        int s; logic rv, mm; logic [31:0] rr;
        access(1'b0, 1'b1, f3, addr, wdata, mask, 1'b0, s, rv, rr, mm);
        check({tag, "_stalls"}, 32'(s), 32'd2);
        check({tag, "_rdv"}, {31'b0, rv}, 32'd0);
    endtask

    // Load on instance A with expected extended data
    task automatic load_a(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
        int s; logic rv, mm; logic [31:0] rr;
        access(1'b0, 1'b0, f3, addr, '0, 4'b1111, 1'b0, s, rv, rr, mm);
        check({tag, "_stalls"}, 32'(s), 32'd2);
        check({tag, "_rdv"}, {31'b0, rv}, 32'd1);
        check({tag, "_data"}, rr, exp);
        check({tag, "_mis"}, {31'b0, mm}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 3'b0, '0, '0, 4'b0);
        set_in(1'b1, 1'b0, 1'b0, 3'b0, '0, '0, 4'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_stall", {31'b0, a_stall}, 32'd0);
        check("rst_rdv", {31'b0, a_rdv}, 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_mis", {31'b0, a_mis}, 32'd0);
        @(posedge clk); #1;

        // Word store then load
        store_a("sw_beef", 3'b010, 32'h100, 32'hDEADBEEF, 4'b1111);
        load_a("lw_beef", 3'b010, 32'h100, 32'hDEADBEEF);

        // Byte store into lane 3, then loads with each extension
        store_a("sw_base", 3'b010, 32'h100, 32'h11223344, 4'b1111);
        store_a("sb", 3'b000, 32'h103, 32'h000000A5, 4'b1000);
        load_a("lb", 3'b000, 32'h103, 32'hFFFFFFA5);
        load_a("lbu", 3'b100, 32'h103, 32'h000000A5);
        load_a("lw_after_sb", 3'b010, 32'h100, 32'hA5223344);
        load_a("lbu_lane0", 3'b100, 32'h100, 32'h00000044);

        // Half store into upper half
        store_a("sw_base2", 3'b010, 32'h200, 32'h55667788, 4'b1111);
        store_a("sh", 3'b001, 32'h202, 32'h00008001, 4'b1100);
        load_a("lh", 3'b001, 32'h202, 32'hFFFF8001);
        load_a("lhu", 3'b101, 32'h202, 32'h00008001);
        load_a("lh_low", 3'b001, 32'h200, 32'h00007788);
        load_a("lw_after_sh", 3'b010, 32'h200, 32'h80017788);

        // Zero mask writes nothing
        store_a("sw_mask0", 3'b010, 32'h200, 32'hFFFFFFFF, 4'b0000);
        load_a("lw_mask0", 3'b010, 32'h200, 32'h80017788);

        // Valid dropping mid-access still completes the load
        access(1'b0, 1'b0, 3'b010, 32'h100, '0, 4'b1111, 1'b1, st, v, d, m);
        check("drop_stalls", 32'(st), 32'd2);
        check("drop_data", d, 32'hA5223344);

        // Reset during BUSY abandons a store
        store_a("sw_pre", 3'b010, 32'h300, 32'h01020304, 4'b1111);
        set_in(1'b0, 1'b1, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 4'b1111);
        @(negedge clk);
        check("rstbusy_stall0", {31'b0, a_stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 3'b0, '0, '0, 4'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstbusy_stall", {31'b0, a_stall}, 32'd0);
        check("rstbusy_rdv", {31'b0, a_rdv}, 32'd0);
        check("rstbusy_rdata", a_rdata, 32'd0);
        check("rstbusy_mis", {31'b0, a_mis}, 32'd0);
        @(posedge clk); #1;
        load_a("lw_nocommit", 3'b010, 32'h300, 32'h01020304);

        // LATENCY=1: stores then back-to-back loads
        access(1'b1, 1'b1, 3'b010, 32'h10, 32'h0BADF00D, 4'b1111, 1'b0, st, v, d, m);
        check("l1_sw0_stalls", 32'(st), 32'd1);
        access(1'b1, 1'b1, 3'b010, 32'h14, 32'h12345678, 4'b1111, 1'b0, st, v, d, m);
        check("l1_sw1_stalls", 32'(st), 32'd1);

        set_in(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, '0, 4'b1111);
        @(negedge clk);
        check("b2b_stall0", {31'b0, b_stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_stall1", {31'b0, b_stall}, 32'd0);
        check("b2b_rdv1", {31'b0, b_rdv}, 32'd1);
        check("b2b_data1", b_rdata, 32'h0BADF00D);
        @(posedge clk); #1;
        set_in(1'b1, 1'b1, 1'b0, 3'b010, 32'h14, '0, 4'b1111);
        @(negedge clk);
        check("b2b_stall2", {31'b0, b_stall}, 32'd1);
        check("b2b_rdv2", {31'b0, b_rdv}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_stall3", {31'b0, b_stall}, 32'd0);
        check("b2b_rdv3", {31'b0, b_rdv}, 32'd1);
        check("b2b_data3", b_rdata, 32'h12345678);
        set_in(1'b1, 1'b0, 1'b0, 3'b0, '0, '0, 4'b0);
        @(posedge clk); #1;

`ifdef DMEM_MISALIGN_CHECK_EN
        // Misaligned word store is suppressed and flagged
        access(1'b0, 1'b1, 3'b010, 32'h101, 32'hFFFFFFFF, 4'b1111, 1'b0, st, v, d, m);
        check("mis_sw_stalls", 32'(st), 32'd2);
        check("mis_sw_flag", {31'b0, m}, 32'd1);
        load_a("mis_sw_mem", 3'b010, 32'h100, 32'hA5223344);
        // Misaligned half load returns zero
        access(1'b0, 1'b0, 3'b001, 32'h103, '0, 4'b1111, 1'b0, st, v, d, m);
        check("mis_lh_stalls", 32'(st), 32'd2);
        check("mis_lh_data", d, 32'd0);
        check("mis_lh_flag", {31'b0, m}, 32'd1);
        @(negedge clk);
        check("mis_after_done", {31'b0, a_mis}, 32'd0);
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
